// File: rtl/mem_hier_ctrl.sv
// mem_hier_ctrl: 2-line fully associative write-back L1 controller with flush and hit/miss counters
module mem_hier_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_hit,
  input  logic              flush_req,
  output logic              flush_done,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);
  typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, RESP, FL_SCAN, FL_WB, FL_DONE} state_t;
  state_t state;
  logic [ADDR_W-1:0] tag [2];
  logic [DATA_W-1:0] data [2];
  logic [1:0] valid, dirty;
  logic lru, v, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic h0, h1, hi, vic;
  assign h0 = valid[0] && tag[0] == addr_q;
  assign h1 = valid[1] && tag[1] == addr_q;
  assign hi = h1;
  assign vic = !valid[0] ? 1'b0 : !valid[1] ? 1'b1 : lru;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      tag[0] <= '0;
      tag[1] <= '0;
      data[0] <= '0;
      data[1] <= '0;
      valid <= '0;
      dirty <= '0;
      lru <= 1'b0;
      v <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      cpu_rdata <= '0;
      cpu_ack <= 1'b0;
      cpu_hit <= 1'b0;
      flush_done <= 1'b0;
      busy <= 1'b0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      hit_cnt <= '0;
      miss_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (flush_req) begin
          v <= 1'b0;
          busy <= 1'b1;
          state <= FL_SCAN;
        end else if (cpu_req) begin
          we_q <= cpu_we;
          addr_q <= cpu_addr;
          wdata_q <= cpu_wdata;
          busy <= 1'b1;
          state <= LOOKUP;
        end
        LOOKUP: if (h0 || h1) begin
          hit_cnt <= hit_cnt + CNT_W'(1);
          lru <= ~hi;
          if (we_q) begin
            data[hi] <= wdata_q;
            dirty[hi] <= 1'b1;
          end
          cpu_rdata <= we_q ? '0 : data[hi];
          cpu_hit <= 1'b1;
          cpu_ack <= 1'b1;
          state <= RESP;
        end else begin
          miss_cnt <= miss_cnt + CNT_W'(1);
          v <= vic;
          if (valid[vic] && dirty[vic]) state <= WB;
          else if (we_q) begin
            tag[vic] <= addr_q;
            data[vic] <= wdata_q;
            valid[vic] <= 1'b1;
            dirty[vic] <= 1'b1;
            lru <= ~vic;
            cpu_rdata <= '0;
            cpu_hit <= 1'b0;
            cpu_ack <= 1'b1;
            state <= RESP;
          end else state <= FILL;
        end
        // cpu write-backs and flush write-backs share one RAM write handshake
        WB, FL_WB: if (!mem_req) begin
          mem_req <= 1'b1;
          mem_we <= 1'b1;
          mem_addr <= tag[v];
          mem_wdata <= data[v];
        end else if (mem_ready) begin
          mem_req <= 1'b0;
          if (state == WB && we_q) begin
            tag[v] <= addr_q;
            data[v] <= wdata_q;
            valid[v] <= 1'b1;
            dirty[v] <= 1'b1;
            lru <= ~v;
            cpu_rdata <= '0;
            cpu_hit <= 1'b0;
            cpu_ack <= 1'b1;
            state <= RESP;
          end else begin
            dirty[v] <= 1'b0;
            state <= (state == FL_WB) ? FL_SCAN : FILL;
          end
        end
        FILL: if (!mem_req) begin
          mem_req <= 1'b1;
          mem_we <= 1'b0;
          mem_addr <= addr_q;
        end else if (mem_ready) begin
          mem_req <= 1'b0;
          tag[v] <= addr_q;
          data[v] <= mem_rdata;
          valid[v] <= 1'b1;
          dirty[v] <= 1'b0;
          lru <= ~v;
          cpu_rdata <= mem_rdata;
          cpu_hit <= 1'b0;
          cpu_ack <= 1'b1;
          state <= RESP;
        end
        RESP: begin
          cpu_ack <= 1'b0;
          cpu_hit <= 1'b0;
          cpu_rdata <= '0;
          busy <= 1'b0;
          state <= IDLE;
        end
        FL_SCAN: if (valid[v] && dirty[v]) state <= FL_WB;
        else if (v) begin
          flush_done <= 1'b1;
          state <= FL_DONE;
        end else v <= 1'b1;
        FL_DONE: begin
          flush_done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_hier_ctrl.sv
// tb_mem_hier_ctrl: directed vector bench for mem_hier_ctrl with a 2-wait-cycle RAM model
module tb_mem_hier_ctrl;
  logic clock = 0, reset_n = 1;
  logic cpu_req = 0, cpu_we = 0, flush_req = 0, mem_ready = 0;
  logic [7:0] cpu_addr = 0, cpu_wdata = 0, mem_rdata = 0;
  logic [7:0] cpu_rdata, mem_addr, mem_wdata, hit_cnt, miss_cnt;
  logic cpu_ack, cpu_hit, flush_done, busy, mem_req, mem_we;

  mem_hier_ctrl dut (
    .clock(clock), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ack(cpu_ack), .cpu_hit(cpu_hit), .flush_req(flush_req),
    .flush_done(flush_done), .busy(busy), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic we;
    logic [7:0] a, wd, rdm, exp_rd;
    logic exp_hit;
    int nwb;
    logic [7:0] wba, wbd;
    int nfill, hits, misses;
  } vec_t;

  vec_t vt [12];
  int total = 0, bad = 0;
  int w, nwr, nrd, rdy_at, ack_at, unstable, late, done_at, acks, seen;
  logic [7:0] wr_a [4], wr_d [4];
  logic [7:0] req_a, req_d, fill_data, got_rd;
  logic req_we, got_hit;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  // one negedge step of the RAM: ready on the third cycle of a held request
  task automatic ram_step(input int k);
    if (mem_ready) begin
      if (mem_req) late++;
      mem_ready = 0;
    end else if (mem_req) begin
      if (w == 0) begin
        req_a = mem_addr;
        req_we = mem_we;
        req_d = mem_wdata;
      end else if ({mem_we, mem_addr, (mem_we ? mem_wdata : 8'h00)} != {req_we, req_a, (req_we ? req_d : 8'h00)}) unstable++;
      if (w == 2) begin
        mem_ready = 1;
        w = 0;
        rdy_at = k;
        if (mem_we) begin
          if (nwr < 4) begin
            wr_a[nwr] = mem_addr;
            wr_d[nwr] = mem_wdata;
          end
          nwr++;
        end else begin
          mem_rdata = fill_data;
          nrd++;
        end
      end else w++;
    end
  endtask

  task automatic op(input vec_t t, input int i);
    @(negedge clock);
    cpu_req = 1;
    cpu_we = t.we;
    cpu_addr = t.a;
    cpu_wdata = t.wd;
    fill_data = t.rdm;
    nwr = 0; nrd = 0; w = 0; unstable = 0; late = 0; ack_at = 0; rdy_at = 0;
    for (int k = 1; k <= 60 && ack_at == 0; k++) begin
      @(negedge clock);
      cpu_req = 0;
      ram_step(k);
      if (cpu_ack) begin
        ack_at = k;
        got_rd = cpu_rdata;
        got_hit = cpu_hit;
      end
    end
    chk($sformatf("v%0d ack_seen", i), ack_at != 0, 1);
    chk($sformatf("v%0d rdata", i), got_rd, t.exp_rd);
    chk($sformatf("v%0d hit", i), got_hit, t.exp_hit);
    chk($sformatf("v%0d n_wb", i), nwr, t.nwb);
    chk($sformatf("v%0d n_fill", i), nrd, t.nfill);
    if (t.nwb > 0) begin
      chk($sformatf("v%0d wb_addr", i), wr_a[0], t.wba);
      chk($sformatf("v%0d wb_data", i), wr_d[0], t.wbd);
    end
    chk($sformatf("v%0d latency", i), ack_at, (nwr + nrd == 0) ? 2 : rdy_at + 1);
    chk($sformatf("v%0d hit_cnt", i), hit_cnt, t.hits);
    chk($sformatf("v%0d miss_cnt", i), miss_cnt, t.misses);
    chk($sformatf("v%0d mem_stable", i), unstable, 0);
    chk($sformatf("v%0d req_drop", i), late, 0);
    @(negedge clock);
    ram_step(0);
    chk($sformatf("v%0d ack_pulse", i), cpu_ack, 0);
    chk($sformatf("v%0d idle", i), busy, 0);
  endtask

  task automatic do_flush(input logic with_cpu, input int n, input logic [7:0] a0, d0, a1, d1,
                          input int h, m);
    @(negedge clock);
    flush_req = 1;
    cpu_req = with_cpu;
    cpu_we = 0;
    cpu_addr = 8'h68;
    nwr = 0; nrd = 0; w = 0; unstable = 0; late = 0; done_at = 0; acks = 0;
    for (int k = 1; k <= 80 && done_at == 0; k++) begin
      @(negedge clock);
      flush_req = 0;
      cpu_req = 0;
      ram_step(k);
      if (cpu_ack) acks++;
      if (flush_done) done_at = k;
    end
    chk("fl done_seen", done_at != 0, 1);
    chk("fl n_wr", nwr, n);
    chk("fl n_rd", nrd, 0);
    chk("fl acks", acks, 0);
    chk("fl wr0_addr", wr_a[0], a0);
    chk("fl wr0_data", wr_d[0], d0);
    if (n == 2) begin
      chk("fl wr1_addr", wr_a[1], a1);
      chk("fl wr1_data", wr_d[1], d1);
    end
    chk("fl mem_stable", unstable, 0);
    chk("fl req_drop", late, 0);
    chk("fl hit_cnt", hit_cnt, h);
    chk("fl miss_cnt", miss_cnt, m);
    @(negedge clock);
    chk("fl done_pulse", flush_done, 0);
    chk("fl idle", busy, 0);
  endtask

  initial begin
    vt[0]  = '{1'b0, 8'h64, 8'h00, 8'h05, 8'h05, 1'b0, 0, 8'h00, 8'h00, 1, 0, 1};
    vt[1]  = '{1'b0, 8'h64, 8'h00, 8'h00, 8'h05, 1'b1, 0, 8'h00, 8'h00, 0, 1, 1};
    vt[2]  = '{1'b1, 8'h65, 8'hAA, 8'h00, 8'h00, 1'b0, 0, 8'h00, 8'h00, 0, 1, 2};
    vt[3]  = '{1'b0, 8'h66, 8'h00, 8'h3C, 8'h3C, 1'b0, 0, 8'h00, 8'h00, 1, 1, 3};
    vt[4]  = '{1'b0, 8'h67, 8'h00, 8'h77, 8'h77, 1'b0, 1, 8'h65, 8'hAA, 1, 1, 4};
    vt[5]  = '{1'b1, 8'h66, 8'h11, 8'h00, 8'h00, 1'b1, 0, 8'h00, 8'h00, 0, 2, 4};
    vt[6]  = '{1'b0, 8'h66, 8'h00, 8'h00, 8'h11, 1'b1, 0, 8'h00, 8'h00, 0, 3, 4};
    vt[7]  = '{1'b1, 8'h67, 8'h22, 8'h00, 8'h00, 1'b1, 0, 8'h00, 8'h00, 0, 4, 4};
    vt[8]  = '{1'b1, 8'h68, 8'h33, 8'h00, 8'h00, 1'b0, 0, 8'h00, 8'h00, 0, 4, 5};
    vt[9]  = '{1'b1, 8'h69, 8'h44, 8'h00, 8'h00, 1'b0, 1, 8'h67, 8'h22, 0, 4, 6};
    vt[10] = '{1'b0, 8'h68, 8'h00, 8'h00, 8'h33, 1'b1, 0, 8'h00, 8'h00, 0, 5, 6};
    vt[11] = '{1'b0, 8'h64, 8'h00, 8'h99, 8'h99, 1'b0, 0, 8'h00, 8'h00, 1, 0, 1};
    #2 reset_n = 0;
    repeat (2) @(negedge clock);
    chk("rst busy", busy, 0);
    chk("rst mem_req", mem_req, 0);
    chk("rst ack", cpu_ack, 0);
    chk("rst flush_done", flush_done, 0);
    chk("rst hit_cnt", hit_cnt, 0);
    chk("rst miss_cnt", miss_cnt, 0);
    reset_n = 1;
    for (int i = 0; i < 6; i++) op(vt[i], i);
    do_flush(1'b0, 1, 8'h66, 8'h11, 8'h00, 8'h00, 2, 4);
    for (int i = 6; i < 10; i++) op(vt[i], i);
    do_flush(1'b1, 2, 8'h68, 8'h33, 8'h69, 8'h44, 4, 6);
    op(vt[10], 10);
    @(negedge clock);
    cpu_req = 1;
    cpu_we = 0;
    cpu_addr = 8'h64;
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      @(negedge clock);
      cpu_req = 0;
      if (mem_req) seen = 1;
    end
    chk("arst fill_reached", seen, 1);
    #2 reset_n = 0;
    #1;
    chk("arst mem_req", mem_req, 0);
    chk("arst busy", busy, 0);
    chk("arst hit_cnt", hit_cnt, 0);
    chk("arst miss_cnt", miss_cnt, 0);
    @(negedge clock);
    reset_n = 1;
    mem_ready = 0;
    w = 0;
    op(vt[11], 11);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
